// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Brief    : Loopback monitor for a multiplexed, active-low seven-segment bus.
//            Re-synchronises segment and anode lines, waits for a stable
//            {anode, segment} pattern, then decodes the glyph back into a BCD
//            digit for the selected position. Also flags illegal glyphs and
//            signals once every position has been refreshed.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
  parameter int DIGITS        = 4,  // multiplexed positions, 1..8
  parameter int STABLE_CYCLES = 8   // identical samples before capture, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  illegal,
  output logic                  frame_done
);

  // Counter holds 0..STABLE_CYCLES-1; one spare bit keeps the width >= 2.
  localparam int              CW     = $clog2(STABLE_CYCLES) + 1;
  localparam int              SW     = DIGITS + 7;
  localparam logic [CW-1:0]   c_last = CW'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] c_all = {DIGITS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // anode vector invalid, nothing to track
    S_TRACK = 2'd1,  // single anode low, counting identical samples
    S_HOLD  = 2'd2   // this dwell already captured, wait for a change
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizers. Reset to all ones so the bus looks dark after reset and
  // the first capture needs a complete stability window.
  // --------------------------------------------------------------------------
  logic [6:0]        r_seg_m;
  logic [6:0]        r_seg_s;
  logic [DIGITS-1:0] r_an_m;
  logic [DIGITS-1:0] r_an_s;

  // Two-flop synchronizer on both asynchronous input buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_m <= '1;
      r_seg_s <= '1;
      r_an_m  <= '1;
      r_an_s  <= '1;
    end else begin
      r_seg_m <= seg;
      r_seg_s <= r_seg_m;
      r_an_m  <= an;
      r_an_s  <= r_an_m;
    end
  end

  // --------------------------------------------------------------------------
  // Sample history and anode qualification
  // --------------------------------------------------------------------------
  logic [SW-1:0]     w_sample;
  logic [SW-1:0]     r_prev;
  logic              w_same;
  logic [DIGITS-1:0] w_an_low;
  logic              w_an_valid;

  assign w_sample   = {r_an_s, r_seg_s};
  assign w_same     = (w_sample == r_prev);
  assign w_an_low   = ~r_an_s;
  // Ghosting shows up as zero or several anodes low; only one-hot is usable.
  assign w_an_valid = $onehot(w_an_low);

  // Previous-sample register used for the change detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '1;
    end else begin
      r_prev <= w_sample;
    end
  end

  // --------------------------------------------------------------------------
  // Glyph decoder (segments active-low, bit 0 = a ... bit 6 = g)
  // --------------------------------------------------------------------------
  logic [3:0] w_glyph_digit;
  logic       w_glyph_legal;
  logic       w_glyph_blank;

  // Map the synchronized segment pattern to a decimal digit, blank or neither.
  always_comb begin
    w_glyph_digit = 4'hF;
    w_glyph_legal = 1'b0;
    w_glyph_blank = 1'b0;
    case (r_seg_s)
      7'b1000000: begin w_glyph_digit = 4'd0; w_glyph_legal = 1'b1; end
      7'b1111001: begin w_glyph_digit = 4'd1; w_glyph_legal = 1'b1; end
      7'b0100100: begin w_glyph_digit = 4'd2; w_glyph_legal = 1'b1; end
      7'b0110000: begin w_glyph_digit = 4'd3; w_glyph_legal = 1'b1; end
      7'b0011001: begin w_glyph_digit = 4'd4; w_glyph_legal = 1'b1; end
      7'b0010010: begin w_glyph_digit = 4'd5; w_glyph_legal = 1'b1; end
      7'b0000011: begin w_glyph_digit = 4'd6; w_glyph_legal = 1'b1; end
      7'b1111000: begin w_glyph_digit = 4'd7; w_glyph_legal = 1'b1; end
      7'b0000000: begin w_glyph_digit = 4'd8; w_glyph_legal = 1'b1; end
      7'b0011000: begin w_glyph_digit = 4'd9; w_glyph_legal = 1'b1; end
      7'b1111111: begin w_glyph_blank = 1'b1; end
      default:    begin end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stability FSM
  // --------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_capture;

  // State and stability-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, next count and the capture strobe. The counter counts
  // "sample equals previous sample" events, so the window is complete when it
  // is about to reach STABLE_CYCLES.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    if (!w_an_valid) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_TRACK;
          w_cnt_next   = '0;
        end
        S_TRACK: begin
          if (!w_same) begin
            w_cnt_next = '0;
          end else if (r_cnt == c_last) begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (!w_same) begin
            w_state_next = S_TRACK;
            w_cnt_next   = '0;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Capture registers, capture mask and event pulses
  // --------------------------------------------------------------------------
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_valid;
  logic [DIGITS-1:0]   r_mask;
  logic                r_illegal;
  logic                r_frame_done;
  logic                w_mask_full;
  logic [DIGITS-1:0]   w_mask_base;
  logic [DIGITS-1:0]   w_cap_bit;

  assign w_mask_full = (r_mask == c_all);
  // A full mask clears on the pulse edge; a capture on that same edge lands
  // on top of the cleared mask and so counts toward the next frame.
  assign w_mask_base = w_mask_full ? '0 : r_mask;
  assign w_cap_bit   = w_capture ? w_an_low : '0;

  // Update the captured position, the refresh mask and the one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd        <= '1;
      r_valid      <= '0;
      r_mask       <= '0;
      r_illegal    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_illegal    <= w_capture && !w_glyph_legal && !w_glyph_blank;
      r_frame_done <= w_mask_full;
      r_mask       <= w_mask_base | w_cap_bit;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_cap_bit[i]) begin
          if (w_glyph_legal) begin
            r_bcd[4*i +: 4] <= w_glyph_digit;
            r_valid[i]      <= 1'b1;
          end else if (w_glyph_blank) begin
            r_bcd[4*i +: 4] <= 4'hF;
            r_valid[i]      <= 1'b0;
          end
        end
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign digit_valid = r_valid;
  assign illegal     = r_illegal;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_capture
// Brief    : Directed and randomized bench for seven_seg_capture. A reference
//            model tracks the bus as a two-cycle delay line plus a run length
//            of identical samples and applies the glyph table directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

  localparam int DIGITS = 4;
  localparam int SC     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        illegal;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int obs_fd;
  int obs_ill;

  logic [6:0] c_glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000011, 7'b1111000,
                               7'b0000000, 7'b0011000};

  seven_seg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .illegal     (illegal),
    .frame_done  (frame_done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [10:0] m_s1, m_s2, m_last;
  int          m_run;
  logic [15:0] m_bcd;
  logic [3:0]  m_valid, m_mask;
  logic        m_ill, m_fd;

  function automatic int glyph_value(input logic [6:0] g);
    for (int i = 0; i < 10; i++) if (g == c_glyph[i]) return i;
    if (g == 7'h7F) return 15;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_last = '1; m_run = 0;
    m_bcd = 16'hFFFF; m_valid = '0; m_mask = '0; m_ill = 1'b0; m_fd = 1'b0;
  endtask

  // One rising edge: the decision uses the input seen two edges earlier; a
  // capture fires when that input has been identical for SC+1 edges.
  task automatic model_edge(input logic [10:0] in);
    logic [10:0] samp;
    logic [3:0]  low;
    int          v;
    bit          cap;
    samp   = m_s2;
    m_s2   = m_s1;
    m_s1   = in;
    if (samp == m_last) m_run++; else m_run = 1;
    m_last = samp;
    low    = ~samp[10:7];
    cap    = ($countones(low) == 1) && (m_run == SC + 1);
    m_fd   = (m_mask == 4'hF);
    if (m_fd) m_mask = '0;
    m_ill  = 1'b0;
    if (cap) begin
      v      = glyph_value(samp[6:0]);
      m_mask = m_mask | low;
      for (int p = 0; p < 4; p++) begin
        if (low[p]) begin
          if (v >= 0 && v <= 9) begin
            m_bcd[4*p +: 4] = 4'(v);
            m_valid[p]      = 1'b1;
          end else if (v == 15) begin
            m_bcd[4*p +: 4] = 4'hF;
            m_valid[p]      = 1'b0;
          end else begin
            m_ill = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd_out",     32'(bcd_out),     32'(m_bcd));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("illegal",     32'(illegal),     32'(m_ill));
    chk("frame_done",  32'(frame_done),  32'(m_fd));
  endtask

  // Drive a pattern for n cycles, advancing the model and checking each cycle.
  task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) model_reset(); else model_edge({a, s});
      #1;
      if (frame_done) obs_fd++;
      if (illegal)    obs_ill++;
      check_all();
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      model_reset();
      #1;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ra;
    logic [3:0] one;
    logic [6:0] rs;
    int         r;
    one   = 4'b0001;
    an    = 4'hF;
    seg   = 7'h7F;
    rst_n = 1'b0;
    obs_fd  = 0;
    obs_ill = 0;

    // Reset then idle bus
    do_reset(3);
    step(4'hF, 7'h7F, 50);
    chk("idle_bcd",   32'(bcd_out), 32'h0000FFFF);
    chk("idle_valid", 32'(digit_valid), 32'h0);
    chk("idle_pulses", 32'(obs_fd + obs_ill), 32'h0);

    // Scan 1,2,3,4 with explicit latency check on position 0
    obs_fd = 0;
    step(4'b1110, c_glyph[1], 10);
    chk("lat_before", 32'(bcd_out[3:0]), 32'hF);
    step(4'b1110, c_glyph[1], 1);
    chk("lat_at_edge10", 32'(bcd_out[3:0]), 32'h1);
    step(4'b1110, c_glyph[1], 9);
    step(4'b1101, c_glyph[2], 20);
    step(4'b1011, c_glyph[3], 20);
    step(4'b0111, c_glyph[4], 20);
    chk("scan_bcd",   32'(bcd_out), 32'h00004321);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_frame_pulses", 32'(obs_fd), 32'h1);

    // Glitch on position 2: 3 for 5 cycles then 4
    step(4'b1011, c_glyph[9], 20);
    obs_ill = 0;
    step(4'b1011, c_glyph[3], 5);
    step(4'b1011, c_glyph[4], 9);
    chk("glitch_hold", 32'(bcd_out[11:8]), 32'h9);
    step(4'b1011, c_glyph[4], 6);
    chk("glitch_bcd", 32'(bcd_out), 32'h00004421);

    // Illegal glyph on position 1 after a 7
    step(4'b1101, c_glyph[7], 20);
    chk("pre_illegal", 32'(bcd_out[7:4]), 32'h7);
    obs_ill = 0;
    step(4'b1101, 7'b0101010, 20);
    chk("illegal_pulses", 32'(obs_ill), 32'h1);
    chk("illegal_bcd",    32'(bcd_out), 32'h00004471);
    chk("illegal_valid",  32'(digit_valid), 32'hF);

    // Ghosting: two anodes low, then blank glyph on position 3
    step(4'b1100, c_glyph[8], 30);
    chk("ghost_bcd",   32'(bcd_out), 32'h00004471);
    chk("ghost_valid", 32'(digit_valid), 32'hF);
    step(4'b0111, 7'h7F, 20);
    chk("blank_bcd",   32'(bcd_out), 32'h0000F471);
    chk("blank_valid", 32'(digit_valid), 32'h7);

    // Reset in the middle of a dwell
    step(4'b1110, c_glyph[5], 5);
    do_reset(2);
    chk("rst_bcd",   32'(bcd_out), 32'h0000FFFF);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    step(4'b1110, c_glyph[5], 10);
    chk("rst_window_open", 32'(bcd_out[3:0]), 32'hF);
    step(4'b1110, c_glyph[5], 1);
    chk("rst_window_done", 32'(bcd_out[3:0]), 32'h5);
    step(4'b1110, c_glyph[5], 4);

    // Randomized dwells, glyphs and anode patterns
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) < 8) ra = ~(one << $urandom_range(0, 3));
      else                          ra = 4'($urandom);
      r = int'($urandom_range(0, 13));
      if (r < 10)       rs = c_glyph[r];
      else if (r == 10) rs = 7'h7F;
      else              rs = 7'($urandom);
      step(ra, rs, int'($urandom_range(2, 25)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
